// File: rtl/tap_host_driver.sv
// Host-side JTAG driver: turns reset / shift-IR / shift-DR / idle commands into
// registered TMS/TDI steps qualified by tck_en, and collects TDO into rsp_data.
module tap_host_driver #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tck_en,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy
);

  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned SYNC_W = 3;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(5);

  localparam logic [1:0] T_RESET = 2'b00;
  localparam logic [1:0] T_IR    = 2'b01;
  localparam logic [1:0] T_IDLE  = 2'b11;

  // State names the next step to issue; the pins always show the step just issued.
  typedef enum logic [3:0] {
    SYNC, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT_UPD, RTI_RET, DONE
  } state_t;

  state_t             state, state_n;
  logic [SYNC_W-1:0]  sync_cnt, sync_cnt_n;
  logic               cmd_act, cmd_act_n;
  logic               is_ir, is_ir_n;
  logic [MAX_LEN-1:0] data_q, data_n;
  logic [IDX_W-1:0]   last_idx, last_n;
  logic [IDX_W-1:0]   bit_cnt, bit_n;
  logic [IDX_W-1:0]   pin_idx, pin_n;
  logic               shift_q, shift_n;
  logic [MAX_LEN-1:0] cap, cap_n;
  logic               tck_en_n, tms_n, tdi_n, cmd_ready_n, busy_n, rsp_valid_n;
  logic [MAX_LEN-1:0] rsp_data_n;
  logic [LEN_W-1:0]   len_eff;
  logic [IDX_W-1:0]   len_last;

  // Effective shift length: 0 acts as 1, anything above MAX_LEN is clamped.
  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (cmd_len > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end
    len_last = IDX_W'(len_eff - LEN_W'(1));
  end

  // State and registered outputs; reset restarts the TLR auto-sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      sync_cnt  <= '0;
      cmd_act   <= 1'b0;
      is_ir     <= 1'b0;
      data_q    <= '0;
      last_idx  <= '0;
      bit_cnt   <= '0;
      pin_idx   <= '0;
      shift_q   <= 1'b0;
      cap       <= '0;
      tck_en    <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      sync_cnt  <= sync_cnt_n;
      cmd_act   <= cmd_act_n;
      is_ir     <= is_ir_n;
      data_q    <= data_n;
      last_idx  <= last_n;
      bit_cnt   <= bit_n;
      pin_idx   <= pin_n;
      shift_q   <= shift_n;
      cap       <= cap_n;
      tck_en    <= tck_en_n;
      tms       <= tms_n;
      tdi       <= tdi_n;
      cmd_ready <= cmd_ready_n;
      busy      <= busy_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
    end
  end

  // Next-step decode: picks the step to put on the pins and captures TDO of a finished shift step.
  always_comb begin
    state_n     = state;
    sync_cnt_n  = sync_cnt;
    cmd_act_n   = cmd_act;
    is_ir_n     = is_ir;
    data_n      = data_q;
    last_n      = last_idx;
    bit_n       = bit_cnt;
    pin_n       = pin_idx;
    shift_n     = 1'b0;
    cap_n       = cap;
    tck_en_n    = 1'b0;
    tms_n       = 1'b0;
    tdi_n       = 1'b0;
    cmd_ready_n = 1'b0;
    busy_n      = 1'b1;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;

    if (shift_q) begin
      cap_n[pin_idx] = tdo;
    end

    case (state)
      SYNC: begin
        tck_en_n = 1'b1;
        tms_n    = (sync_cnt != SYNC_LAST);
        if (sync_cnt == SYNC_LAST) begin
          state_n = DONE;
        end else begin
          sync_cnt_n = sync_cnt + SYNC_W'(1);
        end
      end
      IDLE: begin
        cmd_ready_n = 1'b1;
        busy_n      = 1'b0;
        if (cmd_valid) begin
          // Accept and issue the first step of the command right away.
          cmd_ready_n = 1'b0;
          busy_n      = 1'b1;
          cmd_act_n   = 1'b1;
          cap_n       = '0;
          data_n      = cmd_data;
          last_n      = len_last;
          bit_n       = '0;
          is_ir_n     = (cmd_type == T_IR);
          tck_en_n    = 1'b1;
          case (cmd_type)
            T_RESET: begin
              tms_n      = 1'b1;
              sync_cnt_n = SYNC_W'(1);
              state_n    = SYNC;
            end
            T_IDLE: begin
              tms_n   = 1'b0;
              state_n = DONE;
            end
            default: begin
              tms_n   = 1'b1;
              state_n = SEL_DR;
            end
          endcase
        end
      end
      SEL_DR: begin
        tck_en_n = 1'b1;
        tms_n    = is_ir;
        state_n  = is_ir ? SEL_IR : CAPTURE;
      end
      SEL_IR: begin
        tck_en_n = 1'b1;
        state_n  = CAPTURE;
      end
      CAPTURE: begin
        tck_en_n = 1'b1;
        state_n  = SHIFT;
      end
      SHIFT: begin
        tck_en_n = 1'b1;
        tdi_n    = data_q[bit_cnt];
        shift_n  = 1'b1;
        pin_n    = bit_cnt;
        if (bit_cnt == last_idx) begin
          tms_n   = 1'b1;
          state_n = EXIT_UPD;
        end else begin
          bit_n = bit_cnt + IDX_W'(1);
        end
      end
      EXIT_UPD: begin
        tck_en_n = 1'b1;
        tms_n    = 1'b1;
        state_n  = RTI_RET;
      end
      RTI_RET: begin
        tck_en_n = 1'b1;
        state_n  = DONE;
      end
      DONE: begin
        // Auto-sync ends here too, but only a host command raises rsp_valid.
        cmd_ready_n = 1'b1;
        busy_n      = 1'b0;
        rsp_valid_n = cmd_act;
        if (cmd_act) begin
          rsp_data_n = cap;
        end
        cmd_act_n = 1'b0;
        state_n   = IDLE;
      end
      default: begin
        sync_cnt_n = '0;
        state_n    = SYNC;
      end
    endcase
  end

endmodule

// File: tb/tb_tap_host_driver.sv
// Bench for tap_host_driver: a behavioural 1149.1 TAP target supplies TDO and
// tracks IR/DR updates; command results are checked against rule-derived expectations.
module tb_tap_host_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        tck_en, tms, tdi, tdo;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  tap_host_driver #(.MAX_LEN(32), .LEN_W(6)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .tck_en(tck_en), .tms(tms), .tdi(tdi), .tdo(tdo),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // TAP target model: IEEE 1149.1 state graph, 32-bit DR, 4-bit IR (captures 0101).
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
  localparam int SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

  int          tap_st = SHDR;
  logic [31:0] dr = 32'h0;
  logic [31:0] dr_pre = 32'h0;
  logic [31:0] dr_upd = 32'h0;
  logic [3:0]  ir = 4'h0;
  logic [3:0]  ir_upd = 4'h0;
  int          rsp_cnt = 0;
  logic [1:0]  trace_q[$];
  logic [1:0]  exp_q[$];

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  assign tdo = (tap_st == SHDR) ? dr[0] : (tap_st == SHIR) ? ir[0] : 1'b0;

  // Target advances on qualified edges; every step's {tms,tdi} is logged.
  always @(posedge clk) begin
    if (tck_en) begin
      trace_q.push_back({tms, tdi});
      case (tap_st)
        CDR:  dr <= dr_pre;
        SHDR: dr <= {tdi, dr[31:1]};
        UDR:  dr_upd <= dr;
        CIR:  ir <= 4'b0101;
        SHIR: ir <= {tdi, ir[3:1]};
        UIR:  ir_upd <= ir;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [5:0] len);
    if (len == 6'd0) return 1;
    if (len > 6'd32) return 32;
    return int'(len);
  endfunction

  // Expected response: DR returns the preloaded capture; IR returns capture 0101 then the shifted-in bits.
  function automatic logic [31:0] model_rsp(input logic [1:0] typ, input logic [5:0] len,
                                            input logic [31:0] data, input logic [31:0] pre);
    int n;
    logic [31:0] r;
    logic [3:0] ircap;
    n = eff_len(len);
    r = 32'h0;
    ircap = 4'b0101;
    for (int k = 0; k < n; k++) begin
      if (typ == 2'b10) r[k] = pre[k];
      else if (typ == 2'b01) r[k] = (k < 4) ? ircap[k] : data[k-4];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_dr_upd(input logic [5:0] len, input logic [31:0] data,
                                               input logic [31:0] pre);
    int n;
    n = eff_len(len);
    if (n == 32) return data;
    return (data << (32 - n)) | (pre >> n);
  endfunction

  // Expected pin trace from the TMS/TDI rules of each command type.
  task automatic build_exp(input logic [1:0] typ, input logic [5:0] len, input logic [31:0] data);
    int n;
    n = eff_len(len);
    exp_q.delete();
    case (typ)
      2'b00: for (int i = 0; i < 6; i++) exp_q.push_back({(i < 5) ? 1'b1 : 1'b0, 1'b0});
      2'b11: exp_q.push_back(2'b00);
      default: begin
        exp_q.push_back(2'b10);
        if (typ == 2'b01) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, data[k]});
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
      end
    endcase
  endtask

  task automatic check_trace(input string tag);
    int diffs;
    int lim;
    diffs = 0;
    lim = (trace_q.size() < exp_q.size()) ? trace_q.size() : exp_q.size();
    chk({tag, "_steps"}, 64'(trace_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < lim; i++) if (trace_q[i] !== exp_q[i]) diffs++;
    chk({tag, "_tms_tdi"}, 64'(diffs), 64'd0);
  endtask

  task automatic issue(input logic [1:0] typ, input logic [5:0] len, input logic [31:0] data,
                       input bit keep);
    int i;
    for (i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("ready_timeout", 64'd0, 64'd1);
    trace_q.delete();
    cmd_valid = 1'b1;
    cmd_type  = typ;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge clk);
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
    end
  endtask

  // Waits at falling edges for rsp_valid; counts cycles where cmd_ready was wrongly high.
  task automatic wait_rsp(output logic [31:0] d, output int rdy_hi);
    bit got;
    got = 0;
    rdy_hi = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (cmd_ready) rdy_hi++;
      @(negedge clk);
    end
    if (!got) chk("rsp_timeout", 64'd0, 64'd1);
    d = rsp_data;
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] typ, input logic [5:0] len,
                        input logic [31:0] data, input logic [31:0] pre,
                        input logic [31:0] exp_rsp, input int exp_steps);
    logic [31:0] got;
    int rdy_hi;
    int n;
    n = eff_len(len);
    dr_pre = pre;
    issue(typ, len, data, 0);
    wait_rsp(got, rdy_hi);
    chk({tag, "_rsp"}, 64'(got), 64'(exp_rsp));
    chk({tag, "_ready_busy"}, 64'(rdy_hi), 64'd0);
    build_exp(typ, len, data);
    chk({tag, "_nsteps"}, 64'(exp_q.size()), 64'(exp_steps));
    check_trace(tag);
    chk({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
    if (typ == 2'b10) chk({tag, "_dr_upd"}, 64'(dr_upd), 64'(model_dr_upd(len, data, pre)));
    if (typ == 2'b01 && n >= 4) chk({tag, "_ir_upd"}, 64'(ir_upd), 64'((data >> (n - 4)) & 32'hF));
    @(negedge clk);
    chk({tag, "_idle"}, 64'({rsp_valid, cmd_ready, busy, tck_en}), 64'(4'b0100));
  endtask

  typedef struct {
    string       name;
    logic [1:0]  typ;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] pre;
    logic [31:0] rsp;
    int          steps;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] got;
    int rdy_hi;
    int r0;
    bit found;

    vecs[0] = '{"dr8",    2'b10, 6'd8,  32'h0000_00A5, 32'h0000_003C, 32'h0000_003C, 13};
    vecs[1] = '{"ir4",    2'b01, 6'd4,  32'h0000_000E, 32'h0000_0000, 32'h0000_0005, 10};
    vecs[2] = '{"dr_len0",2'b10, 6'd0,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 6};
    vecs[3] = '{"dr_len40",2'b10,6'd40, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 37};
    vecs[4] = '{"tap_rst",2'b00, 6'd17, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 6};
    vecs[5] = '{"idle",   2'b11, 6'd9,  32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1};
    vecs[6] = '{"ir8",    2'b01, 6'd8,  32'h0000_00A3, 32'h0000_0000, 32'h0000_0035, 14};
    vecs[7] = '{"dr32",   2'b10, 6'd32, 32'h5555_AAAA, 32'h8000_0001, 32'h8000_0001, 37};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_type = 2'b00;
    cmd_len = 6'd0;
    cmd_data = 32'h0;

    // Reset values, then the six-step auto-sync.
    repeat (3) @(negedge clk);
    chk("reset_pins", 64'({tms, tdi, tck_en, cmd_ready, busy, rsp_valid}), 64'(6'b100010));
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("sync_step%0d", c), 64'({tck_en, tms, cmd_ready, busy}),
          64'({1'b1, (c < 6) ? 1'b1 : 1'b0, 1'b0, 1'b1}));
    end
    @(negedge clk);
    chk("sync_done", 64'({tck_en, cmd_ready, busy, rsp_valid}), 64'(4'b0100));
    chk("sync_tap_rti", 64'(tap_st), 64'(RTI));

    for (int v = 0; v < 8; v++)
      do_cmd(vecs[v].name, vecs[v].typ, vecs[v].len, vecs[v].data, vecs[v].pre, vecs[v].rsp, vecs[v].steps);

    // Reset in shift step 3 of a 16-bit DR: immediate reset pins, no response, fresh sync.
    dr_pre = 32'hCAFE_F00D;
    issue(2'b10, 6'd16, 32'h0000_BEEF, 0);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (trace_q.size() == 6) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach_step", 64'(found), 64'd1);
    r0 = rsp_cnt;
    reset = 1'b1;
    #1;
    chk("abort_pins", 64'({tms, tdi, tck_en, cmd_ready, busy, rsp_valid}), 64'(6'b100010));
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    trace_q.delete();
    repeat (7) @(negedge clk);
    build_exp(2'b00, 6'd0, 32'h0);
    check_trace("abort_resync");
    chk("abort_ready", 64'({cmd_ready, busy}), 64'(2'b10));
    chk("abort_no_rsp", 64'(rsp_cnt), 64'(r0));
    chk("abort_tap_rti", 64'(tap_st), 64'(RTI));

    // cmd_valid held through a command; the next one is taken in the completion cycle.
    dr_pre = 32'h1234_5678;
    issue(2'b10, 6'd8, 32'h0000_005A, 1);
    wait_rsp(got, rdy_hi);
    chk("b2b_a_rsp", 64'(got), 64'h78);
    chk("b2b_a_ready_low", 64'(rdy_hi), 64'd0);
    build_exp(2'b10, 6'd8, 32'h0000_005A);
    check_trace("b2b_a");
    chk("b2b_ready_at_rsp", 64'(cmd_ready), 64'd1);
    trace_q.delete();
    cmd_type = 2'b01;
    cmd_len  = 6'd6;
    cmd_data = 32'h0000_002D;
    @(negedge clk);
    chk("b2b_b_first_step", 64'({tck_en, cmd_ready}), 64'(2'b10));
    cmd_valid = 1'b0;
    wait_rsp(got, rdy_hi);
    chk("b2b_b_rsp", 64'(got), 64'h15);
    build_exp(2'b01, 6'd6, 32'h0000_002D);
    check_trace("b2b_b");
    @(negedge clk);

    // Randomized commands against the reference model.
    for (int t = 0; t < 30; t++) begin
      logic [1:0]  rt;
      logic [5:0]  rl;
      logic [31:0] rd, rp;
      rt = 2'($urandom_range(0, 3));
      rl = 6'($urandom_range(0, 45));
      rd = $urandom;
      rp = $urandom;
      build_exp(rt, rl, rd);
      do_cmd($sformatf("rnd%0d", t), rt, rl, rd, rp, model_rsp(rt, rl, rd, rp), exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
